// File: rtl/conf_if.sv
// conf_if: byte-wide configuration stream from the host driver to the CGRA.
interface conf_if;
   logic [7:0] conf_bus;
   logic       conf_valid;
   modport master (output conf_bus, output conf_valid);
   modport slave  (input conf_bus, input conf_valid);
endinterface

// File: rtl/conf_reader.sv
// conf_reader: deframes header + payload byte stream into per-PE config words
// and strobes the addressed PE once per completed frame.
module conf_reader #(
   parameter int NUM_PE     = 9,
   parameter int CONF_BYTES = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   conf_if.slave                   bus,
   output logic [NUM_PE-1:0]       pe_conf_we,
   output logic [CONF_BYTES*8-1:0] pe_conf_data,
   output logic                    busy,
   output logic                    conf_done,
   output logic                    bad_id
);
   localparam int W = CONF_BYTES*8;
   typedef enum logic {IDLE, PAYLOAD} state_t;
   state_t       state;
   logic [2:0]   cnt;
   logic [3:0]   id;
   logic [W-1:0] shift;
   logic [W-1:0] shift_nx;
   logic         id_ok;
   // truncating concat keeps the byte-wise shift legal even when CONF_BYTES is 1
   assign shift_nx = W'({shift, bus.conf_bus});
   assign id_ok    = int'(id) < NUM_PE;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         id           <= '0;
         shift        <= '0;
         pe_conf_we   <= '0;
         pe_conf_data <= '0;
         busy         <= 1'b0;
         conf_done    <= 1'b0;
         bad_id       <= 1'b0;
      end else begin
         pe_conf_we <= '0;
         if (bus.conf_valid) begin
            if (state == IDLE) begin
               if (bus.conf_bus == 8'hFF) conf_done <= 1'b1;
               else if (bus.conf_bus[7]) begin
                  state     <= PAYLOAD;
                  busy      <= 1'b1;
                  conf_done <= 1'b0;
                  id        <= bus.conf_bus[3:0];
                  cnt       <= 3'(CONF_BYTES-1);
               end
            end else begin
               shift <= shift_nx;
               cnt   <= cnt - 3'd1;
               if (cnt == 3'd0) begin
                  state        <= IDLE;
                  busy         <= 1'b0;
                  pe_conf_data <= shift_nx;
                  if (id_ok) pe_conf_we <= NUM_PE'(1) << id;
                  else bad_id <= 1'b1;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_conf_reader.sv
// tb_conf_reader: directed frames with hand-computed strobes and data words.
module tb_conf_reader;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [8:0]  pe_conf_we;
   logic [31:0] pe_conf_data;
   logic        busy, conf_done, bad_id;
   int          vec = 0;
   int          errs = 0;
   conf_if cb();
   conf_reader #(.NUM_PE(9), .CONF_BYTES(4)) dut (
      .clk(clk), .rst_n(rst_n), .bus(cb.slave), .pe_conf_we(pe_conf_we),
      .pe_conf_data(pe_conf_data), .busy(busy), .conf_done(conf_done), .bad_id(bad_id)
   );
   always #5 clk = ~clk;
   // called at a negedge; returns at the next negedge, after the byte was sampled
   task automatic send(input logic [7:0] b);
      cb.conf_bus = b;
      cb.conf_valid = 1'b1;
      @(negedge clk);
      cb.conf_valid = 1'b0;
      cb.conf_bus = 8'hFF;
   endtask
   task automatic gap(input int n);
      cb.conf_valid = 1'b0;
      cb.conf_bus = 8'hFF;
      repeat (n) @(negedge clk);
   endtask
   task automatic test_reset;
      vec++; if ({pe_conf_we, pe_conf_data, busy, conf_done, bad_id} !== 44'd0) begin errs++; $display("FAIL reset_outputs got %h want 0", {pe_conf_we, pe_conf_data, busy, conf_done, bad_id}); end
      @(negedge clk); rst_n = 1'b1; @(negedge clk);
   endtask
   task automatic test_write_pe0;
      logic [7:0] p [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      send(8'h80);
      vec++; if (busy !== 1'b1 || pe_conf_we !== 9'h0) begin errs++; $display("FAIL pe0_hdr busy=%b we=%h want busy=1 we=000", busy, pe_conf_we); end
      for (int i = 0; i < 3; i++) begin
         send(p[i]);
         vec++; if (busy !== 1'b1 || pe_conf_we !== 9'h0) begin errs++; $display("FAIL pe0_byte%0d busy=%b we=%h want busy=1 we=000", i, busy, pe_conf_we); end
      end
      send(p[3]);
      vec++; if (pe_conf_we !== 9'h001 || pe_conf_data !== 32'h11223344 || busy !== 1'b0) begin errs++; $display("FAIL pe0_strobe we=%h data=%h busy=%b want 001 11223344 0", pe_conf_we, pe_conf_data, busy); end
      gap(1);
      vec++; if (pe_conf_we !== 9'h0 || pe_conf_data !== 32'h11223344) begin errs++; $display("FAIL pe0_after we=%h data=%h want 000 11223344", pe_conf_we, pe_conf_data); end
   endtask
   task automatic test_gaps_pe8;
      logic [7:0] b [5] = '{8'h88, 8'h11, 8'h22, 8'h33, 8'h44};
      int g [4] = '{1, 3, 1, 3};
      for (int i = 0; i < 4; i++) begin
         send(b[i]);
         vec++; if (pe_conf_we !== 9'h0 || busy !== 1'b1) begin errs++; $display("FAIL pe8_byte%0d we=%h busy=%b want 000 1", i, pe_conf_we, busy); end
         gap(g[i]);
         vec++; if (pe_conf_we !== 9'h0 || busy !== 1'b1) begin errs++; $display("FAIL pe8_gap%0d we=%h busy=%b want 000 1", i, pe_conf_we, busy); end
      end
      send(b[4]);
      vec++; if (pe_conf_we !== 9'h100 || pe_conf_data !== 32'h11223344) begin errs++; $display("FAIL pe8_strobe we=%h data=%h want 100 11223344", pe_conf_we, pe_conf_data); end
   endtask
   task automatic test_bad_id;
      send(8'h8C); send(8'hFF); send(8'h00); send(8'h7F); send(8'h80);
      vec++; if (pe_conf_we !== 9'h0 || bad_id !== 1'b1 || pe_conf_data !== 32'hFF007F80) begin errs++; $display("FAIL bad_id we=%h bad=%b data=%h want 000 1 ff007f80", pe_conf_we, bad_id, pe_conf_data); end
      send(8'h81); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
      vec++; if (pe_conf_we !== 9'h002 || pe_conf_data !== 32'h01020304 || bad_id !== 1'b1) begin errs++; $display("FAIL after_bad we=%h data=%h bad=%b want 002 01020304 1", pe_conf_we, pe_conf_data, bad_id); end
   endtask
   task automatic test_filler_end;
      send(8'h00); send(8'h7F);
      vec++; if (busy !== 1'b0 || conf_done !== 1'b0 || pe_conf_we !== 9'h0) begin errs++; $display("FAIL filler busy=%b done=%b we=%h want 0 0 000", busy, conf_done, pe_conf_we); end
      send(8'hFF);
      vec++; if (conf_done !== 1'b1 || busy !== 1'b0 || pe_conf_we !== 9'h0) begin errs++; $display("FAIL end_cmd done=%b busy=%b we=%h want 1 0 000", conf_done, busy, pe_conf_we); end
      send(8'h83);
      vec++; if (conf_done !== 1'b0 || busy !== 1'b1) begin errs++; $display("FAIL write_clears_done done=%b busy=%b want 0 1", conf_done, busy); end
      send(8'hFF); send(8'hFF); send(8'h80); send(8'h01);
      vec++; if (pe_conf_we !== 9'h008 || pe_conf_data !== 32'hFFFF8001 || conf_done !== 1'b0) begin errs++; $display("FAIL pe3_ff_payload we=%h data=%h done=%b want 008 ffff8001 0", pe_conf_we, pe_conf_data, conf_done); end
   endtask
   task automatic test_mid_reset;
      send(8'h82); send(8'hAA); send(8'hBB);
      #2 rst_n = 1'b0;
      #1;
      vec++; if ({pe_conf_we, pe_conf_data, busy, conf_done, bad_id} !== 44'd0) begin errs++; $display("FAIL async_reset got %h want 0", {pe_conf_we, pe_conf_data, busy, conf_done, bad_id}); end
      @(negedge clk); rst_n = 1'b1;
      send(8'h82); send(8'h01); send(8'h02); send(8'h03);
      vec++; if (pe_conf_we !== 9'h0 || busy !== 1'b1) begin errs++; $display("FAIL no_residue we=%h busy=%b want 000 1", pe_conf_we, busy); end
      send(8'h04);
      vec++; if (pe_conf_we !== 9'h004 || pe_conf_data !== 32'h01020304 || bad_id !== 1'b0) begin errs++; $display("FAIL post_reset we=%h data=%h bad=%b want 004 01020304 0", pe_conf_we, pe_conf_data, bad_id); end
   endtask
   task automatic test_back_to_back;
      int t0, t1;
      send(8'h80); send(8'hA1); send(8'hA2); send(8'hA3); send(8'hA4);
      t0 = $time;
      vec++; if (pe_conf_we !== 9'h001 || pe_conf_data !== 32'hA1A2A3A4) begin errs++; $display("FAIL b2b_first we=%h data=%h want 001 a1a2a3a4", pe_conf_we, pe_conf_data); end
      send(8'h81);
      vec++; if (pe_conf_we !== 9'h0 || busy !== 1'b1) begin errs++; $display("FAIL b2b_hdr we=%h busy=%b want 000 1", pe_conf_we, busy); end
      send(8'hB1); send(8'hB2); send(8'hB3); send(8'hB4);
      t1 = $time;
      vec++; if (pe_conf_we !== 9'h002 || pe_conf_data !== 32'hB1B2B3B4) begin errs++; $display("FAIL b2b_second we=%h data=%h want 002 b1b2b3b4", pe_conf_we, pe_conf_data); end
      vec++; if (t1 - t0 !== 50) begin errs++; $display("FAIL b2b_spacing got %0d ns want 50 ns", t1 - t0); end
   endtask
   initial begin
      cb.conf_bus = 8'h00;
      cb.conf_valid = 1'b0;
      @(negedge clk);
      test_reset;
      test_write_pe0;
      test_gaps_pe8;
      test_bad_id;
      test_filler_end;
      test_mid_reset;
      test_back_to_back;
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule
